tstamp_serializer: RTL and testbench

Readout stage directly downstream of the timestamp FIFO (`hcc_syncFifo_latC`, WORDWIDTH=16). Pops one timestamp word at a time and sends it off chip on a single pad as a framed serial stream: fixed header, data MSB first, even parity. The stream is qualified by a frame strobe, so one data pad plus one strobe pad replace the 16 parallel timestamp pads.

---
 rtl/tstamp_serializer.sv | 100 ++++++++++
 tb/tb_tstamp_serializer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/tstamp_serializer.sv
// tstamp_serializer
// Pops timestamp words from a first-word-fall-through FIFO and sends each one
// off chip as a framed serial stream on a single pad:
//   {HEADER[3:0], data[WORDWIDTH-1:0], even parity over data}, MSB first,
// qualified by a frame strobe. After each frame the strobe is held low for
// GAP idle cycles before the next word may be popped.
//
// Ports
//   clk           system clock
//   rstb          async active-low reset
//   enable_i      readout enable, sampled only when a frame could start
//   fifo_data_i   FIFO head word (valid while fifo_empty_i=0)
//   fifo_empty_i  FIFO empty flag
//   fifo_re_o     pop strobe, combinational, IDLE only
//   ser_data_o    serial data (registered)
//   ser_frame_o   frame strobe (registered)
//   busy_o        high outside IDLE (registered)
//   frame_cnt_o   completed-frame counter, wraps at 256
module tstamp_serializer #(
  parameter int         WORDWIDTH = 16,
  parameter logic [3:0] HEADER    = 4'b1010,
  parameter int         GAP       = 1
) (
  input  logic                 clk,
  input  logic                 rstb,
  input  logic                 enable_i,
  input  logic [WORDWIDTH-1:0] fifo_data_i,
  input  logic                 fifo_empty_i,
  output logic                 fifo_re_o,
  output logic                 ser_data_o,
  output logic                 ser_frame_o,
  output logic                 busy_o,
  output logic [7:0]           frame_cnt_o
);

  localparam int F  = 4 + WORDWIDTH + 1;
  localparam int CW = $clog2(F);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, GAP_S} state_t;

  state_t          state;
  logic [F-1:0]    sr;       // bits still to be sent, next one in the MSB
  logic [CW-1:0]   bit_cnt;  // index of the bit currently on ser_data_o
  logic [GW-1:0]   gap_cnt;

  // Gated by rstb so no pop can be seen by the FIFO while reset is held.
  assign fifo_re_o = rstb & (state == IDLE) & enable_i & ~fifo_empty_i;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state       <= IDLE;
      sr          <= '0;
      bit_cnt     <= '0;
      gap_cnt     <= '0;
      ser_data_o  <= 1'b0;
      ser_frame_o <= 1'b0;
      busy_o      <= 1'b0;
      frame_cnt_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (fifo_re_o) begin
            // Header bit 3 goes straight to the output register so it is on
            // the pad the cycle after the pop; the rest waits in sr.
            sr          <= {HEADER[2:0], fifo_data_i, ^fifo_data_i, 1'b0};
            ser_data_o  <= HEADER[3];
            ser_frame_o <= 1'b1;
            busy_o      <= 1'b1;
            bit_cnt     <= '0;
            state       <= SHIFT;
          end
        end
        SHIFT: begin
          if (bit_cnt == CW'(F - 1)) begin
            ser_data_o  <= 1'b0;
            ser_frame_o <= 1'b0;
            frame_cnt_o <= frame_cnt_o + 8'd1;
            gap_cnt     <= '0;
            state       <= GAP_S;
          end else begin
            ser_data_o <= sr[F-1];
            sr         <= {sr[F-2:0], 1'b0};
            bit_cnt    <= bit_cnt + CW'(1);
          end
        end
        GAP_S: begin
          if (gap_cnt == GW'(GAP - 1)) begin
            busy_o <= 1'b0;
            state  <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tstamp_serializer.sv
module tb_tstamp_serializer;

  logic        clk, rstb, enable_i, fifo_empty_i;
  logic [15:0] fifo_data_i;
  logic        fifo_re_o, ser_data_o, ser_frame_o, busy_o;
  logic [7:0]  frame_cnt_o;

  tstamp_serializer #(.WORDWIDTH(16), .HEADER(4'b1010), .GAP(1)) dut (
    .clk(clk), .rstb(rstb), .enable_i(enable_i),
    .fifo_data_i(fifo_data_i), .fifo_empty_i(fifo_empty_i),
    .fifo_re_o(fifo_re_o), .ser_data_o(ser_data_o), .ser_frame_o(ser_frame_o),
    .busy_o(busy_o), .frame_cnt_o(frame_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [15:0] w; logic [20:0] f; } ent_t;
  typedef struct { logic [20:0] f; int start; } exp_t;

  ent_t fifo_q[$];
  exp_t exp_q[$];
  int   pop_cyc_q[$];
  int   nvec = 0, nerr = 0;
  int   cyc = 0, re_cyc = 0, pops = 0;
  logic re_s = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive_fifo;
    fifo_empty_i = (fifo_q.size() == 0);
    fifo_data_i  = fifo_empty_i ? 16'h0 : fifo_q[0].w;
  endtask

  task automatic push_word(input logic [15:0] w, input logic [20:0] f);
    ent_t e;
    e.w = w; e.f = f;
    fifo_q.push_back(e);
    drive_fifo();
  endtask

  // Inputs change at posedge+3, between the FIFO update and the negedge sample.
  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #3; end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    re_s   = fifo_re_o;
    re_cyc = cyc;
  end

  // FIFO model: pop on the edge after fifo_re_o was seen high; each pop is the
  // stimulus event that issues the expected frame into the scoreboard.
  always @(posedge clk) begin
    exp_t x;
    #1;
    if (re_s && rstb) begin
      if (fifo_q.size() == 0) begin
        check("pop_from_empty", 32'd1, 32'd0);
      end else begin
        x.f = fifo_q[0].f;
        x.start = re_cyc + 1;
        void'(fifo_q.pop_front());
        exp_q.push_back(x);
        pop_cyc_q.push_back(re_cyc);
        pops++;
        drive_fifo();
      end
    end
  end

  // Monitor: assembles each strobed frame and compares with the scoreboard.
  logic        in_frame = 1'b0, cur_ok = 1'b0;
  logic [20:0] got;
  int          len;
  exp_t        cur;
  always @(negedge clk) begin
    if (!rstb) begin
      in_frame = 1'b0;
      exp_q.delete();
    end else if (ser_frame_o) begin
      if (!in_frame) begin
        in_frame = 1'b1; len = 0; got = '0;
        if (exp_q.size() == 0) begin
          cur_ok = 1'b0;
          check("frame_unexpected", 32'd1, 32'd0);
        end else begin
          cur = exp_q.pop_front();
          cur_ok = 1'b1;
          check("frame_start", cyc, cur.start);
        end
      end
      got = {got[19:0], ser_data_o};
      len++;
    end else if (in_frame) begin
      in_frame = 1'b0;
      if (cur_ok) begin
        check("frame_bits", {11'd0, got}, {11'd0, cur.f});
        check("frame_len", len, 21);
      end
    end
  end

  initial begin
    logic act;
    int   p0, bad, k;
    logic [15:0] w;
    rstb = 1'b0; enable_i = 1'b0;
    drive_fifo();
    tick(3);
    check("rst_data",  {31'd0, ser_data_o}, 0);
    check("rst_frame", {31'd0, ser_frame_o}, 0);
    check("rst_busy",  {31'd0, busy_o}, 0);
    check("rst_cnt",   {24'd0, frame_cnt_o}, 0);
    // Pop must stay low while reset is held even with enable and data present.
    enable_i = 1'b1;
    push_word(16'h5555, 21'b1010_0101010101010101_0);
    #1 check("rst_re", {31'd0, fifo_re_o}, 0);

    // Single word
    tick(1); rstb = 1'b1;
    tick(30);
    check("single_cnt", {24'd0, frame_cnt_o}, 1);
    check("single_pops", pops, 1);

    // Parity
    push_word(16'h0001, 21'b1010_0000000000000001_1);
    push_word(16'hFFFF, 21'b1010_1111111111111111_0);
    tick(60);
    check("parity_cnt", {24'd0, frame_cnt_o}, 3);

    // Back-to-back, 23-cycle period
    pop_cyc_q.delete();
    push_word(16'h1234, 21'b1010_0001001000110100_1);
    push_word(16'hABCD, 21'b1010_1010101111001101_0);
    push_word(16'h0000, 21'b1010_0000000000000000_0);
    tick(80);
    check("b2b_pops", pop_cyc_q.size(), 3);
    if (pop_cyc_q.size() == 3) begin
      check("b2b_gap1", pop_cyc_q[1] - pop_cyc_q[0], 23);
      check("b2b_gap2", pop_cyc_q[2] - pop_cyc_q[1], 23);
    end
    check("b2b_cnt", {24'd0, frame_cnt_o}, 6);

    // Enable low with data waiting
    enable_i = 1'b0;
    push_word(16'h00FF, 21'b1010_0000000011111111_0);
    act = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      act = act | fifo_re_o | ser_frame_o | busy_o | ser_data_o;
    end
    check("dis_idle", {31'd0, act}, 0);
    enable_i = 1'b1;
    tick(30);
    check("dis_cnt", {24'd0, frame_cnt_o}, 7);

    // Enable dropped at bit 8
    p0 = pops;
    push_word(16'h8000, 21'b1010_1000000000000000_1);
    push_word(16'h7FFF, 21'b1010_0111111111111111_1);
    k = 0;
    while (!ser_frame_o && k < 40) begin tick(1); k++; end
    check("drop_start_seen", {31'd0, ser_frame_o}, 1);
    tick(8);
    enable_i = 1'b0;
    tick(40);
    check("drop_pops", pops - p0, 1);
    check("drop_left", fifo_q.size(), 1);
    check("drop_cnt", {24'd0, frame_cnt_o}, 8);
    fifo_q.delete(); drive_fifo();

    // Reset at bit 10
    enable_i = 1'b1;
    push_word(16'h0F0F, 21'b1010_0000111100001111_0);
    k = 0;
    while (!ser_frame_o && k < 40) begin tick(1); k++; end
    tick(10);
    rstb = 1'b0;
    #1;
    check("mrst_out", {28'd0, fifo_re_o, ser_frame_o, busy_o, ser_data_o}, 0);
    check("mrst_cnt", {24'd0, frame_cnt_o}, 0);
    tick(2); rstb = 1'b1;
    act = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      act = act | fifo_re_o | ser_frame_o | busy_o | ser_data_o;
    end
    check("mrst_quiet", {31'd0, act}, 0);
    check("mrst_cnt2", {24'd0, frame_cnt_o}, 0);

    // Counter wrap
    pop_cyc_q.delete();
    for (int i = 0; i < 256; i++) begin
      w = 16'(i * 16'h0101 + 16'h3);
      push_word(w, {4'b1010, w, 1'($countones(w) % 2)});
    end
    k = 0;
    while (frame_cnt_o != 8'd255 && k < 256 * 23 + 100) begin tick(1); k++; end
    check("wrap_255", {24'd0, frame_cnt_o}, 255);
    k = 0;
    while (frame_cnt_o == 8'd255 && k < 40) begin tick(1); k++; end
    check("wrap_0", {24'd0, frame_cnt_o}, 0);
    bad = 0;
    for (int i = 1; i < pop_cyc_q.size(); i++)
      if (pop_cyc_q[i] - pop_cyc_q[i-1] != 23) bad++;
    check("wrap_pops", pop_cyc_q.size(), 256);
    check("wrap_period", bad, 0);
    tick(5);
    check("exp_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
